adsr_envelope: RTL
==================

Name: adsr_envelope

Overview:
- Amplitude-envelope stage between the sine generator and the PWM DAC pair.
- Takes the unsigned positive and negative half-wave samples and scales both by an 8-bit attack/decay/sustain/release envelope.
- Note start and stop come from the melody sequencer as note_on / note_off strobes.
- The envelope advances only on the sample-rate strobe. This removes clicks at note boundaries and lets note-to-note gaps be shaped.

Parameters:
- N, 7, sample width of pos/neg inputs and outputs (matches DAC width).
- ENV_W, 8, envelope level width; full scale = 2^ENV_W-1 = 255.
- ATTACK_STEP, 16, level increment per sample_tick in ATTACK.
- DECAY_STEP, 2, level decrement per sample_tick in DECAY.
- SUSTAIN_LEVEL, 160, hold level in SUSTAIN; must be < 255.
- RELEASE_STEP, 4, level decrement per sample_tick in RELEASE.

Ports:
- clk  in  1  system clock (1 MHz)
- reset  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-clk strobe at fs (8 kHz)
- note_on  in  1  one-clk strobe: start or retrigger a note
- note_off  in  1  one-clk strobe: release current note
- pos_in  in  N  positive half-wave sample, unsigned
- neg_in  in  N  negative half-wave sample, unsigned magnitude
- pos_out  out  N  scaled positive sample to DAC t_on
- neg_out  out  N  scaled negative sample to DAC t_on
- env_level  out  ENV_W  current envelope level
- env_state  out  3  current state encoding
- note_done  out  1  one-clk pulse when RELEASE reaches 0

Behaviour:
- Reset (reset low, async): state IDLE; env_level, pos_out, neg_out = 0; note_done = 0.
- States: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Strobes are sampled on every clk edge; state and level change only on the edge where their condition holds.
- note_on (any state): go to ATTACK immediately. Level is NOT cleared; attack continues from the current level (click-free retrigger).
- note_off in ATTACK/DECAY/SUSTAIN: go to RELEASE, level unchanged.
- note_off in IDLE or RELEASE: ignored.
- note_on and note_off on the same clk: note_on wins.
- Level updates only when sample_tick=1. A strobe arriving on the same clk as sample_tick takes effect first; the level step uses the new state on the next tick.
- ATTACK, on tick: if level + ATTACK_STEP >= 255, set level = 255 and go to DECAY; else level += ATTACK_STEP. Compute in ENV_W+1 bits, no wrap.
- DECAY, on tick: if level <= SUSTAIN_LEVEL + DECAY_STEP, set level = SUSTAIN_LEVEL and go to SUSTAIN; else level -= DECAY_STEP.
- SUSTAIN: level held until note_off or note_on.
- RELEASE, on tick: if level <= RELEASE_STEP, set level = 0, go to IDLE, and pulse note_done on that clk; else level -= RELEASE_STEP.
- IDLE: level held at 0.
- Scaling: pos_out = (pos_in * env_level) >> ENV_W, and likewise for neg_out.
  - Full N+ENV_W product, truncated.
  - Registered every clk, so latency = 1 clk from pos_in/env_level to output.
  - At full scale, output = in - 1 for in > 0 (accepted).
- Reset asserted mid-note: immediate return to IDLE with zero outputs; no note_done pulse.

Decomposition:
- Shared package adsr_pkg:
  - env_state_t enum (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, 3 bits).
  - ENV_MAX constant (255).
- Sub-module env_scale (params N, ENV_W):
  - Registered multiply-and-shift of one sample by env_level; same clk/reset.
  - Instantiated twice, for pos and neg.
- The FSM and level counter stay in adsr_envelope.

Test Plan:
- Reset: hold reset low with pos_in=100 -> env_level=0, pos_out=0, env_state=0; release reset with no note_on -> outputs stay 0.
- Attack/decay/sustain: note_on, then continuous ticks ->
  - level 16, 32, ..., 240, then 255 on tick 16 (state DECAY);
  - 253, ..., then 160 on decay tick 48 (state SUSTAIN);
  - with pos_in=100 held: pos_out=99 at level 255 and 62 at level 160, one clk after the level changes.
- Release: note_off in SUSTAIN -> level drops by 4 per tick, reaches 0 on tick 40; state IDLE and note_done high exactly one clk on that edge.
- Retrigger: note_on during RELEASE at level 80 -> ATTACK from 80, next tick gives 96; level never drops to 0 in between.
- Simultaneous strobes: note_on and note_off on the same clk while in SUSTAIN -> state ATTACK.
- Async reset mid-ATTACK at level 128: reset low between clk edges -> level and outputs are 0 immediately; note_done stays 0.

Source files
------------

// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - shared envelope state encoding and level limits
//
// Contents:
//   env_state_t : envelope phase encoding, 3 bits
//                 (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4)
//   ENV_MAX     : full-scale envelope level for the default 8-bit level width
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int unsigned ENV_MAX = 255;

endpackage

// File: rtl/env_scale.sv
// rtl/env_scale.sv - registered multiply-and-shift of one sample by the envelope level
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous, active-low reset (clears dout)
//   din       : unsigned sample, N bits
//   env_level : envelope level, ENV_W bits
//   dout      : (din * env_level) >> ENV_W, registered (1 clk latency)
module env_scale #(
  parameter int unsigned N     = 7,
  parameter int unsigned ENV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     din,
  input  logic [ENV_W-1:0] env_level,
  output logic [N-1:0]     dout
);

  // Full-width product; dropping the low ENV_W bits truncates, so full scale
  // gives din-1 for any nonzero din.
  logic [N+ENV_W-1:0] prod;

  assign prod = {{ENV_W{1'b0}}, din} * {{N{1'b0}}, env_level};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= '0;
    end else begin
      dout <= N'(prod >> ENV_W);
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR amplitude envelope applied to the positive and negative half-wave samples
//
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   sample_tick : one-clk strobe at the sample rate; level only moves on it
//   note_on     : one-clk strobe, start or retrigger a note (wins over note_off)
//   note_off    : one-clk strobe, release the current note
//   pos_in      : positive half-wave sample, unsigned, N bits
//   neg_in      : negative half-wave sample magnitude, N bits
//   pos_out     : pos_in scaled by env_level, 1 clk latency
//   neg_out     : neg_in scaled by env_level, 1 clk latency
//   env_level   : current envelope level, ENV_W bits
//   env_state   : current envelope phase (adsr_pkg::env_state_t encoding)
//   note_done   : one-clk pulse on the edge where RELEASE reaches 0
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int unsigned N             = 7,
  parameter int unsigned ENV_W         = 8,
  parameter int unsigned ATTACK_STEP   = 16,
  parameter int unsigned DECAY_STEP    = 2,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             note_on,
  input  logic             note_off,
  input  logic [N-1:0]     pos_in,
  input  logic [N-1:0]     neg_in,
  output logic [N-1:0]     pos_out,
  output logic [N-1:0]     neg_out,
  output logic [ENV_W-1:0] env_level,
  output logic [2:0]       env_state,
  output logic             note_done
);

  // Comparisons run one bit wider than the level so nothing wraps.
  localparam logic [ENV_W:0]   LVL_MAX   = (ENV_W+1)'(ENV_MAX);
  localparam logic [ENV_W:0]   ATT_STEP  = (ENV_W+1)'(ATTACK_STEP);
  localparam logic [ENV_W:0]   DEC_FLOOR = (ENV_W+1)'(SUSTAIN_LEVEL + DECAY_STEP);
  localparam logic [ENV_W-1:0] DEC_STEP  = ENV_W'(DECAY_STEP);
  localparam logic [ENV_W-1:0] SUS_LVL   = ENV_W'(SUSTAIN_LEVEL);
  localparam logic [ENV_W-1:0] REL_STEP  = ENV_W'(RELEASE_STEP);

  env_state_t     state;
  logic [ENV_W:0] att_sum;

  assign att_sum   = {1'b0, env_level} + ATT_STEP;
  assign env_state = state;

  // Strobes take priority over the level step on the same edge, so a
  // strobe coinciding with sample_tick only changes state; the level then
  // steps under the new state on the following tick. Retrigger keeps the
  // current level so the attack ramps from wherever the note was.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      env_level <= '0;
      note_done <= 1'b0;
    end else begin
      note_done <= 1'b0;
      if (note_on) begin
        state <= ATTACK;
      end else if (note_off && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
        state <= RELEASE;
      end else if (sample_tick) begin
        case (state)
          ATTACK: begin
            if (att_sum >= LVL_MAX) begin
              env_level <= LVL_MAX[ENV_W-1:0];
              state     <= DECAY;
            end else begin
              env_level <= att_sum[ENV_W-1:0];
            end
          end
          DECAY: begin
            if ({1'b0, env_level} <= DEC_FLOOR) begin
              env_level <= SUS_LVL;
              state     <= SUSTAIN;
            end else begin
              env_level <= env_level - DEC_STEP;
            end
          end
          SUSTAIN: begin
            env_level <= env_level;
          end
          RELEASE: begin
            if (env_level <= REL_STEP) begin
              env_level <= '0;
              state     <= IDLE;
              note_done <= 1'b1;
            end else begin
              env_level <= env_level - REL_STEP;
            end
          end
          default: begin
            env_level <= '0;
          end
        endcase
      end
    end
  end

  env_scale #(.N(N), .ENV_W(ENV_W)) u_scale_pos (
    .clk       (clk),
    .reset     (reset),
    .din       (pos_in),
    .env_level (env_level),
    .dout      (pos_out)
  );

  env_scale #(.N(N), .ENV_W(ENV_W)) u_scale_neg (
    .clk       (clk),
    .reset     (reset),
    .din       (neg_in),
    .env_level (env_level),
    .dout      (neg_out)
  );

endmodule
